// File: rtl/pc_unit_if.sv
// Fetch PC unit bundle: stall/redirect/exception controls in,
// fetch PC, PC+4, pending flag and fetch-error flag out.
interface pc_unit_if #(
  parameter int WIDTH = 32
);
  logic             En;
  logic             ExcReq;
  logic             Eret;
  logic [WIDTH-1:0] EPC;
  logic             Redirect;
  logic [WIDTH-1:0] RedirectTarget;
  logic [WIDTH-1:0] PC;
  logic [WIDTH-1:0] PCPlus4;
  logic             RedirectPending;
  logic             FetchExc;

  modport master (
    output En, ExcReq, Eret, EPC,
    output Redirect, RedirectTarget,
    input  PC, PCPlus4,
    input  RedirectPending, FetchExc
  );

  modport slave (
    input  En, ExcReq, Eret, EPC,
    input  Redirect, RedirectTarget,
    output PC, PCPlus4,
    output RedirectPending, FetchExc
  );
endinterface

// File: rtl/pc_unit.sv
// Fetch program counter: Clk/Reset (sync, active-high) plus the
// pc_unit_if slave port carrying stall, redirect and exception controls.
module pc_unit #(
  parameter int             WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VEC = WIDTH'(32'h0000_3000),
  parameter logic [WIDTH-1:0] EXC_VEC   = WIDTH'(32'h0000_4180),
  parameter logic [WIDTH-1:0] ADDR_LO   = WIDTH'(32'h0000_3000),
  parameter logic [WIDTH-1:0] ADDR_HI   = WIDTH'(32'h0000_6FFC)
) (
  input logic      Clk,
  input logic      Reset,
  pc_unit_if.slave bus
);

  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] tgt_q, tgt_d;
  logic             pend_q, pend_d;
  logic [WIDTH-1:0] pc_plus4;

  assign pc_plus4 = pc_q + WIDTH'(4);

  always_comb begin
    pc_d   = pc_q;
    tgt_d  = tgt_q;
    pend_d = pend_q;
    if (bus.ExcReq) begin
      pc_d   = EXC_VEC;
      tgt_d  = '0;
      pend_d = 1'b0;
    end else if (bus.Eret) begin
      pc_d   = bus.EPC;
      tgt_d  = '0;
      pend_d = 1'b0;
    end else if (bus.En) begin
      tgt_d  = '0;
      pend_d = 1'b0;
      if (bus.Redirect)
        pc_d = bus.RedirectTarget;
      else if (pend_q)
        pc_d = tgt_q;
      else
        pc_d = pc_plus4;
    end else if (bus.Redirect) begin
      // stalled: hold PC, remember newest redirect
      tgt_d  = bus.RedirectTarget;
      pend_d = 1'b1;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      pc_q   <= RESET_VEC;
      tgt_q  <= '0;
      pend_q <= 1'b0;
    end else begin
      pc_q   <= pc_d;
      tgt_q  <= tgt_d;
      pend_q <= pend_d;
    end
  end

  assign bus.PC              = pc_q;
  assign bus.PCPlus4         = pc_plus4;
  assign bus.RedirectPending = pend_q;
  assign bus.FetchExc        = (pc_q[1:0] != 2'b00)
                             || (pc_q < ADDR_LO)
                             || (pc_q > ADDR_HI);

endmodule
